// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Purpose : bundles the sequencer's instruction/memory handshake inputs and the
//           datapath control strobes into one port.
// Signals :
//   opcode[6:0]  IR[6:0], meaningful from DECODE onward      (datapath -> ctl)
//   mem_ready    memory completes current read/write         (datapath -> ctl)
//   halt         hold in FETCH without issuing a fetch       (datapath -> ctl)
//   iord, ir_write, pc_inc, branch, memread, memwrite,
//   memtoreg, alusrc, regwrite, aluop[1:0]  datapath strobes (ctl -> datapath)
//   retire, illegal   one-cycle status pulses                (ctl -> datapath)
//   instret[CNT_W-1:0] retired-instruction count             (ctl -> datapath)
// Modports: master = the sequencer, slave = the datapath side.
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             halt;
    logic             iord;
    logic             ir_write;
    logic             pc_inc;
    logic             branch;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             alusrc;
    logic             regwrite;
    logic [1:0]       aluop;
    logic             retire;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, mem_ready, halt,
        output iord, ir_write, pc_inc, branch, memread, memwrite,
               memtoreg, alusrc, regwrite, aluop, retire, illegal, instret
    );

    modport slave (
        output opcode, mem_ready, halt,
        input  iord, ir_write, pc_inc, branch, memread, memwrite,
               memtoreg, alusrc, regwrite, aluop, retire, illegal, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Purpose : five-state (FETCH/DECODE/EXEC/MEM/WB) sequencer for the RV32 subset
//           R-type, LW, SW, BEQ sharing one memory port between instruction
//           fetch and data access. Counts retired instructions and flags
//           unsupported opcodes.
// Ports   :
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   bus     multicycle_control_if.master (handshake inputs, control strobes,
//           retire/illegal pulses, instret counter)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    multicycle_control_if.master bus
);

    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_RT   = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4
    } cls_t;

    state_t           r_state;
    cls_t             r_class;
    logic [CNT_W-1:0] r_instret;

    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_inc;
    logic       w_branch;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_alusrc;
    logic       w_regwrite;
    logic [1:0] w_aluop;
    logic       w_retire;
    logic       w_illegal;
    logic       w_supported;

    // Opcode is only a valid encoding of a supported instruction in DECODE.
    always_comb begin
        w_supported = (bus.opcode == OP_RT) || (bus.opcode == OP_LW) ||
                      (bus.opcode == OP_SW) || (bus.opcode == OP_BEQ);
    end

    // Sequencer state, latched instruction class and retired-instruction count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_FETCH;
            r_class   <= CLS_NONE;
            r_instret <= {CNT_W{1'b0}};
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_instret <= r_instret;
            end
            case (r_state)
                ST_FETCH: begin
                    r_class <= CLS_NONE;
                    if (!bus.halt && bus.mem_ready) begin
                        r_state <= ST_DECODE;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXEC;
                    case (bus.opcode)
                        OP_RT:   r_class <= CLS_RT;
                        OP_LW:   r_class <= CLS_LW;
                        OP_SW:   r_class <= CLS_SW;
                        OP_BEQ:  r_class <= CLS_BEQ;
                        default: begin
                            r_class <= CLS_NONE;
                            r_state <= ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC: begin
                    case (r_class)
                        CLS_RT:          r_state <= ST_WB;
                        CLS_LW, CLS_SW:  r_state <= ST_MEM;
                        default:         r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    // The strobe is held until memory answers; LW still
                    // needs its write-back cycle, SW is done here.
                    if (bus.mem_ready) begin
                        if (r_class == CLS_LW) begin
                            r_state <= ST_WB;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_state <= ST_MEM;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Strobe decode from state, latched class and same-cycle mem_ready;
    // everything stays quiet while reset is held.
    always_comb begin
        w_iord     = 1'b0;
        w_ir_write = 1'b0;
        w_pc_inc   = 1'b0;
        w_branch   = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_aluop    = 2'b00;
        w_retire   = 1'b0;
        w_illegal  = 1'b0;
        if (i_rst) begin
            w_retire = 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!bus.halt) begin
                        w_memread = 1'b1;
                        if (bus.mem_ready) begin
                            w_ir_write = 1'b1;
                            w_pc_inc   = 1'b1;
                        end else begin
                            w_ir_write = 1'b0;
                        end
                    end else begin
                        w_memread = 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (!w_supported) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_illegal = 1'b0;
                    end
                end
                ST_EXEC: begin
                    case (r_class)
                        CLS_RT: w_aluop = 2'b10;
                        CLS_LW, CLS_SW: begin
                            w_aluop  = 2'b00;
                            w_alusrc = 1'b1;
                        end
                        CLS_BEQ: begin
                            w_aluop  = 2'b01;
                            w_branch = 1'b1;
                            w_retire = 1'b1;
                        end
                        default: w_aluop = 2'b00;
                    endcase
                end
                ST_MEM: begin
                    w_iord = 1'b1;
                    if (r_class == CLS_LW) begin
                        w_memread = 1'b1;
                    end else begin
                        w_memwrite = 1'b1;
                        w_retire   = bus.mem_ready;
                    end
                end
                ST_WB: begin
                    w_regwrite = 1'b1;
                    w_memtoreg = (r_class == CLS_LW);
                    w_retire   = 1'b1;
                end
                default: w_retire = 1'b0;
            endcase
        end
    end

    assign bus.iord     = w_iord;
    assign bus.ir_write = w_ir_write;
    assign bus.pc_inc   = w_pc_inc;
    assign bus.branch   = w_branch;
    assign bus.memread  = w_memread;
    assign bus.memwrite = w_memwrite;
    assign bus.memtoreg = w_memtoreg;
    assign bus.alusrc   = w_alusrc;
    assign bus.regwrite = w_regwrite;
    assign bus.aluop    = w_aluop;
    assign bus.retire   = w_retire;
    assign bus.illegal  = w_illegal;
    assign bus.instret  = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Builds a per-cycle expected trace for each instruction straight from the
// instruction's cycle recipe (fetch stalls, decode, execute, memory stalls,
// write-back), then replays it against the sequencer. A 4-bit counter makes
// the instret wrap show up within the run.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int CW = 4;

    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Observed vector: {iord, ir_write, pc_inc, branch, memread, memwrite,
    //                   memtoreg, alusrc, regwrite, aluop[1:0], retire, illegal}
    localparam logic [12:0] B_IORD     = 13'h1000;
    localparam logic [12:0] B_IRW      = 13'h0800;
    localparam logic [12:0] B_PCINC    = 13'h0400;
    localparam logic [12:0] B_BRANCH   = 13'h0200;
    localparam logic [12:0] B_MEMREAD  = 13'h0100;
    localparam logic [12:0] B_MEMWRITE = 13'h0080;
    localparam logic [12:0] B_MEMTOREG = 13'h0040;
    localparam logic [12:0] B_ALUSRC   = 13'h0020;
    localparam logic [12:0] B_REGWRITE = 13'h0010;
    localparam logic [12:0] B_ALU10    = 13'h0008;
    localparam logic [12:0] B_ALU01    = 13'h0004;
    localparam logic [12:0] B_RETIRE   = 13'h0002;
    localparam logic [12:0] B_ILL      = 13'h0001;

    typedef struct {
        logic        rst;
        logic        halt;
        logic        rdy;
        logic [6:0]  op;
        logic [12:0] exp;
        logic        chk;
    } cyc_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   model_cnt;
    cyc_t q[$];

    multicycle_control_if #(.CNT_W(CW)) bus ();

    multicycle_control #(.CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [12:0] obs;
    assign obs = {bus.iord, bus.ir_write, bus.pc_inc, bus.branch, bus.memread,
                  bus.memwrite, bus.memtoreg, bus.alusrc, bus.regwrite,
                  bus.aluop, bus.retire, bus.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic push(input logic r, input logic h, input logic rd,
                        input logic [6:0] op, input logic [12:0] e,
                        input logic c);
        cyc_t x;
        x.rst = r; x.halt = h; x.rdy = rd; x.op = op; x.exp = e; x.chk = c;
        q.push_back(x);
    endtask

    // kind: 0 RT, 1 LW, 2 SW, 3 BEQ, 4 unsupported (illop).
    // halt is a don't-care outside FETCH: random, or forced high with hf.
    task automatic gen(input int kind, input int fst, input int mst,
                       input bit abrt, input bit hf, input logic [6:0] illop);
        logic [6:0]  op;
        logic [12:0] e;
        case (kind)
            0:       op = OP_RT;
            1:       op = OP_LW;
            2:       op = OP_SW;
            3:       op = OP_BEQ;
            default: op = illop;
        endcase
        for (int i = 0; i < fst; i++)
            push(1'b0, 1'b0, 1'b0, rnd7(), B_MEMREAD, 1'b1);
        push(1'b0, 1'b0, 1'b1, rnd7(), B_MEMREAD | B_IRW | B_PCINC, 1'b1);
        push(1'b0, hf | rbit(), rbit(), op, (kind == 4) ? B_ILL : 13'd0, 1'b1);
        if (kind == 4) return;
        if (kind == 0)      e = B_ALU10;
        else if (kind == 3) e = B_ALU01 | B_BRANCH | B_RETIRE;
        else                e = B_ALUSRC;
        push(1'b0, hf | rbit(), rbit(), rnd7(), e, 1'b1);
        if (kind == 1 || kind == 2) begin
            e = B_IORD | ((kind == 1) ? B_MEMREAD : B_MEMWRITE);
            for (int i = 0; i < mst; i++)
                push(1'b0, hf | rbit(), 1'b0, rnd7(), e, 1'b1);
            if (abrt) begin
                push(1'b1, 1'b0, 1'b0, rnd7(), 13'd0, 1'b0);
                push(1'b1, 1'b0, 1'b0, rnd7(), 13'd0, 1'b1);
                return;
            end
            push(1'b0, hf | rbit(), 1'b1, rnd7(),
                 e | ((kind == 2) ? B_RETIRE : 13'd0), 1'b1);
        end
        if (kind == 0 || kind == 1)
            push(1'b0, hf | rbit(), rbit(), rnd7(),
                 B_REGWRITE | B_RETIRE | ((kind == 1) ? B_MEMTOREG : 13'd0), 1'b1);
    endtask

    task automatic idle_halt(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b1, rbit(), rnd7(), 13'd0, 1'b1);
    endtask

    initial begin
        cyc_t        c;
        logic [6:0]  iop;
        int          k;
        n_total   = 0;
        n_bad     = 0;
        model_cnt = 0;
        rst           = 1'b1;
        bus.halt      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = 7'd0;

        // Reset held two cycles; both follow a reset edge.
        push(1'b1, 1'b0, 1'b0, 7'd0, 13'd0, 1'b1);
        push(1'b1, 1'b0, 1'b0, 7'd0, 13'd0, 1'b1);
        // SW aborted by reset while stalled in MEM.
        gen(2, 0, 2, 1'b1, 1'b0, 7'd0);
        gen(0, 0, 0, 1'b0, 1'b0, 7'd0);          // RT
        gen(1, 2, 3, 1'b0, 1'b0, 7'd0);          // LW, 10 cycles
        gen(2, 0, 0, 1'b0, 1'b0, 7'd0);          // SW
        gen(3, 0, 0, 1'b0, 1'b0, 7'd0);          // BEQ
        gen(4, 0, 0, 1'b0, 1'b0, 7'b0010011);    // unsupported
        idle_halt(5);
        gen(0, 0, 0, 1'b0, 1'b1, 7'd0);          // RT with halt raised in flight
        idle_halt(3);
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 4);
            iop = rnd7();
            while (iop == OP_RT || iop == OP_LW || iop == OP_SW || iop == OP_BEQ)
                iop = rnd7();
            gen(k, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, iop);
            if ($urandom_range(0, 7) == 0) idle_halt($urandom_range(1, 3));
        end

        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst           = c.rst;
            bus.halt      = c.halt;
            bus.mem_ready = c.rdy;
            bus.opcode    = c.op;
            @(negedge clk);
            if (c.chk) begin
                check_eq("strobes", {19'd0, obs}, {19'd0, c.exp});
                check_eq("instret", {28'd0, bus.instret}, 32'(model_cnt));
            end
            if (c.rst)
                model_cnt = 0;
            else if (c.exp[1])
                model_cnt = (model_cnt + 1) % (1 << CW);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32 core subset (R-type, LW, SW, BEQ). It replaces single-cycle decode with a five-state FSM that shares one memory port between instruction fetch and data access. Each datapath control strobe is asserted only in the cycle where it applies. It also counts retired instructions and flags unsupported opcodes. It sits between the instruction register and the datapath: register file, ALU, ALU control, PC and unified memory.

## Interface
- CNT_W, default 32: width of retired-instruction counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- halt  in  1  hold in FETCH without issuing a fetch.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_inc  out  1  PC <= PC + 4.
- branch  out  1  PC <= branch target if ALU zero.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- memtoreg  out  1  register write-back source: 1 = memory data, 0 = ALU.
- alusrc  out  1  ALU operand B: 1 = immediate, 0 = rs2.
- regwrite  out  1  register file write enable.
- aluop  out  2  to ALU control: 00 add, 01 subtract/compare, 10 funct-decoded.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Opcodes: RT = 0110011, LW = 0000011, SW = 0100011, BEQ = 1100011.
- States: FETCH, DECODE, EXEC, MEM, WB. Opcode class is registered in DECODE and held until the next FETCH.

- FETCH
  - halt = 1: stay, all strobes 0.
  - Otherwise: memread = 1, iord = 0.
  - If mem_ready = 1: ir_write = 1 and pc_inc = 1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE
  - Supported opcode: go to EXEC.
  - Unsupported opcode: illegal = 1, go to FETCH. Not counted; retire = 0.
- EXEC
  - RT: aluop = 10, alusrc = 0; go to WB.
  - LW/SW: aluop = 00, alusrc = 1; go to MEM.
  - BEQ: aluop = 01, alusrc = 0, branch = 1, retire = 1; go to FETCH.
- MEM (iord = 1)
  - LW: memread = 1; when mem_ready = 1 go to WB.
  - SW: memwrite = 1; when mem_ready = 1, retire = 1 and go to FETCH.
  - Without mem_ready: stay, with the strobe held asserted.
- WB
  - regwrite = 1; memtoreg = 1 for LW, 0 for RT; retire = 1; go to FETCH.

- Outputs are decoded from state, latched class and mem_ready. ir_write, pc_inc and retire in MEM depend on mem_ready in the same cycle.
- Every strobe not listed for a state is 0. aluop = 00 and alusrc = 0 outside EXEC.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- halt is sampled only in FETCH. An instruction already in flight runs to completion.

## Timing
- Reset: state = FETCH, class = none, instret = 0, all outputs 0.
  - The first fetch strobe appears in the cycle after rst deasserts, if halt = 0.
  - rst mid-instruction aborts it: no retire, no further strobes, and memwrite drops in the same edge.
- Cycles per instruction with zero wait states (mem_ready = 1 whenever a strobe is asserted):
  - BEQ 3, RT 4, SW 4, LW 5.
  - Unsupported opcode: 2 cycles.
  - Each cycle that mem_ready = 0 while a memory strobe is asserted adds one cycle.
- memread and memwrite are never asserted in the same cycle. iord is stable for the whole duration of each strobe.
- retire and illegal are never asserted in the same cycle. At most one of them pulses per instruction.
- mem_ready asserted while no strobe is active is ignored.

## Test plan
- Reset, then RT with mem_ready tied to 1 → strobes per cycle:
  - FETCH: memread, ir_write, pc_inc.
  - DECODE: none.
  - EXEC: aluop = 10.
  - WB: regwrite = 1, memtoreg = 0, retire.
  - instret = 1.
- LW with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM → 10 cycles total. memread and iord are held steady during the stalls. WB has memtoreg = 1. retire fires exactly once.
- SW then BEQ back-to-back → SW: memwrite = 1 with iord = 1 for 1 cycle, retire on the MEM cycle. BEQ: branch = 1, aluop = 01 in EXEC, retire on that cycle. instret = 2 after 7 cycles.
- Opcode 0010011 → illegal pulses in DECODE, no retire, instret unchanged, next FETCH begins on the following cycle.
- halt = 1 while idle in FETCH for 5 cycles → no strobes. halt asserted during an RT EXEC → the instruction completes through WB, then the FSM holds in FETCH with memread = 0.
- rst asserted during SW MEM with mem_ready = 0 → next cycle: state FETCH, memwrite = 0, instret unchanged. Preload instret to all-ones with CNT_W = 4, then retire one instruction → instret = 0.
